// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared state encoding, funct3 codes and divide special-case constants.
package muldiv_pkg;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} muldiv_state_t;
  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;
  localparam logic [31:0] MD_DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] MD_INT_MIN   = 32'h8000_0000;
endpackage

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: Execute-stage request/stall/result bundle for the M-extension unit.
interface muldiv_sequencer_if #(parameter int XLEN = 32);
  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] src_a_i;
  logic [XLEN-1:0] src_b_i;
  logic            flush_e_i;
  logic            stall_o;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;
  modport master (output start_i, op_i, src_a_i, src_b_i, flush_e_i, input stall_o, busy_o, done_o, result_o);
  modport slave (input start_i, op_i, src_a_i, src_b_i, flush_e_i, output stall_o, busy_o, done_o, result_o);
endinterface

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: one-bit-per-cycle shift-add multiplier / restoring divider with sign fix-up.
// MULDIV_DIV_EN adds the restoring-divide step; without it only the multiply step exists.
module muldiv_datapath import muldiv_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_n_i,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            neg_i,
  input  logic            rneg_i,
  output logic [XLEN-1:0] res_o
);
  logic [2*XLEN-1:0] acc_q, acc_d, prod;
  logic [XLEN-1:0] b_q, quot, rem;
  logic [XLEN:0] sum;
`ifdef MULDIV_DIV_EN
  logic borrow;
  logic [XLEN-1:0] rdiff;
`endif
  always_ff @(posedge clk_i)
    if (!reset_n_i) begin
      acc_q <= '0;
      b_q   <= '0;
    end else if (load_i) begin
      acc_q <= {{XLEN{1'b0}}, a_i};
      b_q   <= b_i;
    end else if (step_i)
      acc_q <= acc_d;
  // acc holds {product_hi, multiplier} for multiply and {remainder, quotient} for divide
  always_comb begin
    sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    acc_d = {sum, acc_q[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
    {borrow, rdiff} = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
    if (op_i[2])
      acc_d = borrow ? {acc_q[2*XLEN-2:0], 1'b0} : {rdiff, acc_q[XLEN-2:0], 1'b1};
`endif
    prod  = neg_i ? -acc_q : acc_q;
    quot  = neg_i ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem   = rneg_i ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    res_o = op_i == MD_MUL ? prod[XLEN-1:0] : !op_i[2] ? prod[2*XLEN-1:XLEN] : !op_i[1] ? quot : rem;
  end
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: FSM, iteration counter, stall/done and operand latching for the RV32M unit.
// MULDIV_DIV_EN enables divide and its special cases; otherwise divides complete at once with 0.
module muldiv_sequencer import muldiv_pkg::*; #(
  parameter int XLEN  = 32,
  parameter int ITERS = XLEN
) (
  input logic               clk_i,
  input logic               reset_n_i,
  muldiv_sequencer_if.slave bus
);
  localparam int CW = $clog2(ITERS + 1);
  muldiv_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] op_q;
  logic neg_q, rneg_q, a_neg, b_neg, accept, special, step;
  logic [XLEN-1:0] result_q, result_d, abs_a, abs_b, special_res, dp_res;
  always_ff @(posedge clk_i)
    if (!reset_n_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      op_q     <= MD_MUL;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      if (accept) begin
        op_q   <= bus.op_i;
        neg_q  <= a_neg ^ b_neg;
        rneg_q <= a_neg;
      end
    end
  always_comb begin
    accept = state_q == S_IDLE && bus.start_i && !bus.flush_e_i;
    a_neg  = bus.src_a_i[XLEN-1] && (bus.op_i inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
    b_neg  = bus.src_b_i[XLEN-1] && (bus.op_i inside {MD_MULH, MD_DIV, MD_REM});
    abs_a  = a_neg ? -bus.src_a_i : bus.src_a_i;
    abs_b  = b_neg ? -bus.src_b_i : bus.src_b_i;
`ifdef MULDIV_DIV_EN
    special = bus.op_i[2] && (bus.src_b_i == '0 ||
              (!bus.op_i[0] && bus.src_a_i == MD_INT_MIN && bus.src_b_i == '1));
    special_res = bus.src_b_i == '0 ? (bus.op_i[1] ? bus.src_a_i : MD_DIV0_QUOT)
                                    : (bus.op_i[1] ? '0 : MD_INT_MIN);
`else
    special     = bus.op_i[2];
    special_res = '0;
`endif
    step     = state_q == S_BUSY;
    cnt_d    = accept ? '0 : step ? cnt_q + 1'b1 : cnt_q;
    result_d = accept && special ? special_res :
               state_q == S_FIX && !bus.flush_e_i ? dp_res : result_q;
    state_d  = bus.flush_e_i ? S_IDLE :
               state_q == S_IDLE ? (accept ? (special ? S_DONE : S_BUSY) : S_IDLE) :
               state_q == S_BUSY ? (cnt_q == CW'(ITERS - 1) ? S_FIX : S_BUSY) :
               state_q == S_FIX  ? S_DONE : S_IDLE;
  end
  assign bus.stall_o  = accept || state_q inside {S_BUSY, S_FIX};
  assign bus.busy_o   = state_q != S_IDLE;
  assign bus.done_o   = state_q == S_DONE;
  assign bus.result_o = result_q;
  muldiv_datapath #(.XLEN(XLEN)) u_dp (
    .clk_i(clk_i),
    .reset_n_i(reset_n_i),
    .load_i(accept),
    .step_i(step),
    .op_i(op_q),
    .a_i(abs_a),
    .b_i(abs_b),
    .neg_i(neg_q),
    .rneg_i(rneg_q),
    .res_o(dp_res)
  );
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed RV32M vectors checked against a cycle-timeline/arithmetic model.
// Divide vectors depend on MULDIV_DIV_EN.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;
  logic clk_i = 1'b0;
  logic reset_n_i = 1'b0;
  int cyc = 0, checks = 0, errors = 0;
  bit chk_en = 1'b0;
  bit act = 1'b0;
  int t0 = 0, lat = 0;
  logic [31:0] pend = '0, hold = '0;
  muldiv_sequencer_if bus ();
  muldiv_sequencer dut (.clk_i(clk_i), .reset_n_i(reset_n_i), .bus(bus));
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;
  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub, p;
    logic signed [31:0] a32, b32;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    a32 = a;
    b32 = b;
    case (op)
      MD_MUL:    begin p = ua * ub; return p[31:0]; end
      MD_MULH:   begin p = sa * sb; return p[63:32]; end
      MD_MULHSU: begin p = sa * $signed(ub); return p[63:32]; end
      MD_MULHU:  begin p = ua * ub; return p[63:32]; end
      default: ;
    endcase
`ifdef MULDIV_DIV_EN
    case (op)
      MD_DIV:  return b == 0 ? 32'hFFFF_FFFF : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(a32 / b32);
      MD_REM:  return b == 0 ? a : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(a32 % b32);
      MD_DIVU: return b == 0 ? 32'hFFFF_FFFF : a / b;
      default: return b == 0 ? a : a % b;
    endcase
`else
    return 32'h0;
`endif
  endfunction
  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_DIV_EN
    if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`else
    if (op[2]) return 1;
`endif
    return 34;
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %08h want %08h at cycle %0d", name, got, want, cyc);
    end
  endtask
  // model: an accepted op occupies cycles t0..t0+lat; done on the last, stall on all but the last
  always @(negedge clk_i) if (chk_en) begin
    logic e_done, e_busy, e_stall;
    if (!act && bus.start_i && !bus.flush_e_i) begin
      act  = 1'b1;
      t0   = cyc;
      lat  = ref_lat(bus.op_i, bus.src_a_i, bus.src_b_i);
      pend = ref_res(bus.op_i, bus.src_a_i, bus.src_b_i);
    end
    e_done  = act && cyc == t0 + lat;
    e_busy  = act && cyc > t0;
    e_stall = act && cyc < t0 + lat;
    chk("m_stall", bus.stall_o, e_stall);
    chk("m_busy", bus.busy_o, e_busy);
    chk("m_done", bus.done_o, e_done);
    chk("m_result", bus.result_o, e_done ? pend : hold);
    if (!reset_n_i) begin
      act  = 1'b0;
      hold = '0;
    end else if (bus.flush_e_i)
      act = 1'b0;
    else if (e_done) begin
      act  = 1'b0;
      hold = pend;
    end
  end
  task automatic run(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] want, input int want_lat);
    int n = 0;
    @(posedge clk_i); #1;
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.src_a_i = a;
    bus.src_b_i = b;
    @(posedge clk_i); #1;
    bus.start_i = 1'b0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      @(negedge clk_i);
      if (bus.done_o) n = i;
    end
    chk({name, "_lat"}, n, want_lat);
    chk(name, bus.result_o, want);
  endtask
  task automatic start_mul_hold(input int cycles);
    @(posedge clk_i); #1;
    bus.start_i = 1'b1;
    bus.op_i    = MD_MUL;
    bus.src_a_i = 32'd5;
    bus.src_b_i = 32'd6;
    @(posedge clk_i); #1;
    bus.start_i = 1'b0;
    repeat (cycles - 1) @(posedge clk_i);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end
  initial begin
    bus.start_i = 1'b0;
    bus.op_i = MD_MUL;
    bus.src_a_i = '0;
    bus.src_b_i = '0;
    bus.flush_e_i = 1'b0;
    chk("pin_mul", ref_res(MD_MUL, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    chk("pin_mulh", ref_res(MD_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'h0);
    chk("pin_mulhu", ref_res(MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
`ifdef MULDIV_DIV_EN
    chk("pin_div", ref_res(MD_DIV, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    chk("pin_rem", ref_res(MD_REM, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
`endif
    repeat (3) @(posedge clk_i);
    #1 reset_n_i = 1'b1;
    chk_en = 1'b1;
    @(negedge clk_i);
    chk("rst_busy", bus.busy_o, 1'b0);
    chk("rst_done", bus.done_o, 1'b0);
    chk("rst_stall", bus.stall_o, 1'b0);
    chk("rst_result", bus.result_o, 32'h0);
    run("mul_7", MD_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    run("mulhu_ff", MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    run("mulh_ff", MD_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 34);
    run("mulhsu_m1x2", MD_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 34);
`ifdef MULDIV_DIV_EN
    run("div_m7", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    run("rem_m7", MD_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    run("remu_100", MD_REMU, 32'd100, 32'd7, 32'd2, 34);
    run("divu_100", MD_DIVU, 32'd100, 32'd7, 32'd14, 34);
    run("divu_by0", MD_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run("rem_by0", MD_REM, 32'd5, 32'd0, 32'd5, 1);
    run("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run("rem_ovf", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
`else
    run("div_off", MD_DIV, 32'd10, 32'd2, 32'h0, 1);
    run("rem_off", MD_REMU, 32'd10, 32'd3, 32'h0, 1);
`endif
    run("mul_3x4", MD_MUL, 32'd3, 32'd4, 32'd12, 34);
    start_mul_hold(10);
    bus.flush_e_i = 1'b1;
    @(posedge clk_i); #1;
    bus.flush_e_i = 1'b0;
    @(negedge clk_i);
    chk("flush_busy", bus.busy_o, 1'b0);
    chk("flush_stall", bus.stall_o, 1'b0);
    chk("flush_result", bus.result_o, 32'd12);
    repeat (40) @(negedge clk_i);
    start_mul_hold(20);
    reset_n_i = 1'b0;
    @(posedge clk_i); #1;
    reset_n_i = 1'b1;
    @(negedge clk_i);
    chk("mrst_busy", bus.busy_o, 1'b0);
    chk("mrst_done", bus.done_o, 1'b0);
    chk("mrst_stall", bus.stall_o, 1'b0);
    chk("mrst_result", bus.result_o, 32'h0);
    @(posedge clk_i); #1;
    bus.start_i = 1'b1;
    bus.flush_e_i = 1'b1;
    bus.op_i = MD_MUL;
    @(negedge clk_i);
    chk("sf_stall", bus.stall_o, 1'b0);
    @(posedge clk_i); #1;
    bus.start_i = 1'b0;
    bus.flush_e_i = 1'b0;
    @(negedge clk_i);
    chk("sf_busy", bus.busy_o, 1'b0);
    repeat (40) @(negedge clk_i);
    run("mul_after", MD_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 34);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
